// File: rtl/fifo_sync_param.sv
// Synchronous FIFO with power-of-2 depth, occupancy flags and sticky error flags.
// Read latency: 0 cycles when OUT_REG=0 (combinational), 1 cycle when OUT_REG=1.
// No internal backpressure: a write to a full FIFO without a same-cycle read is dropped and sets overflow.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   w_en, data_in       write request and write word
//   r_en                read request
//   data_out, rd_valid  read word and its valid qualifier (timing set by OUT_REG)
//   full, empty         occupancy at the limits
//   almost_full         count >= AF_LEVEL
//   count               occupancy, 0..1<<INDEX
//   overflow, underflow sticky error flags, cleared only by rst
module fifo_sync_param #(
  parameter int WIDTH    = 17,
  parameter int INDEX    = 1,
  parameter int AF_LEVEL = 1,
  parameter int OUT_REG  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_en,
  input  logic             r_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [INDEX:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << INDEX;
  localparam logic [INDEX:0] FULL_CNT = (INDEX + 1)'(DEPTH);
  localparam logic [INDEX:0] AF_CNT   = (INDEX + 1)'(AF_LEVEL);

  // Reject illegal configurations while elaborating.
  if (INDEX < 1) begin : g_bad_index
    $error("fifo_sync_param: INDEX must be >= 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL must be in 1..1<<INDEX");
  end
  if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_outreg
    $error("fifo_sync_param: OUT_REG must be 0 or 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [INDEX-1:0] w_ptr;
  logic [INDEX-1:0] r_ptr;
  logic             rd_ok;
  logic             wr_ok;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_CNT);

  // A read never bypasses a same-cycle write into an empty FIFO. A write into a
  // full FIFO is allowed when a read frees a slot in the same cycle; in that
  // case w_ptr == r_ptr, and the old word is read before it is overwritten.
  assign rd_ok = r_en & ~empty;
  assign wr_ok = w_en & (~full | rd_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem[w_ptr] <= data_in;
        w_ptr      <= w_ptr + 1'b1;   // natural wrap at 1<<INDEX
      end
      if (rd_ok) begin
        r_ptr <= r_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (w_en && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (r_en && !rd_ok) begin
        underflow <= 1'b1;
      end
    end
  end

  if (OUT_REG == 0) begin : g_comb_out
    // Zero-latency legacy mode: the output is forced to zero unless a read is accepted.
    assign data_out = rd_ok ? mem[r_ptr] : '0;
    assign rd_valid = rd_ok;
  end else begin : g_reg_out
    // Registered mode: data_out holds the last accepted word between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_out <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_ok;
        if (rd_ok) begin
          data_out <= mem[r_ptr];
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Testbench for fifo_sync_param: two instances (combinational and registered
// output) share stimulus and are compared against a queue-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
module tb_fifo_sync_param;
  localparam int W     = 17;
  localparam int IDX   = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         w_en = 1'b0;
  logic         r_en = 1'b0;
  logic [W-1:0] data_in = '0;

  logic [W-1:0] dout0, dout1;
  logic         rv0, rv1, full0, full1, empty0, empty1, af0, af1;
  logic         ovf0, ovf1, udf0, udf1;
  logic [IDX:0] cnt0, cnt1;
  logic [7:0]   st0, st1;

  assign st0 = {full0, empty0, af0, cnt0, ovf0, udf0};
  assign st1 = {full1, empty1, af1, cnt1, ovf1, udf1};

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(W), .INDEX(IDX), .AF_LEVEL(AF), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .data_out(dout0), .rd_valid(rv0), .full(full0), .empty(empty0),
    .almost_full(af0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

  fifo_sync_param #(.WIDTH(W), .INDEX(IDX), .AF_LEVEL(AF), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .data_out(dout1), .rd_valid(rv1), .full(full1), .empty(empty1),
    .almost_full(af1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the FIFO contents are simply a queue.
  logic [W-1:0] q[$];
  bit           m_ovf, m_udf, m_rv1;
  logic [W-1:0] m_d1 = '0;
  bit           e_w, e_r, e_rd_ok, e_wr_ok;
  logic [W-1:0] e_din, e_dout0;

  function automatic logic [7:0] exp_flags();
    int n = q.size();
    return {n == DEPTH, n == 0, n >= AF, 3'(n), m_ovf, m_udf};
  endfunction

  // Apply inputs for one cycle and move to the sampling point.
  task automatic step(input bit w, input bit r, input logic [W-1:0] d);
    w_en = w; r_en = r; data_in = d;
    e_w = w; e_r = r; e_din = d;
    e_rd_ok = r && (q.size() != 0);
    e_wr_ok = w && ((q.size() < DEPTH) || e_rd_ok);
    e_dout0 = e_rd_ok ? q[0] : '0;
    #4;
  endtask

  // Clock edge: update the model the way the FIFO rules describe.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_rv1 = 0; m_d1 = '0;
    end else begin
      if (e_rd_ok) begin
        m_d1  = q.pop_front();
        m_rv1 = 1;
      end else begin
        m_rv1 = 0;
      end
      if (e_wr_ok) q.push_back(e_din);
      if (e_w && !e_wr_ok) m_ovf = 1;
      if (e_r && !e_rd_ok) m_udf = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1, 1, W'($urandom));
    advance();
    step(0, 0, '0);
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step(0, 0, '0);
    n_checks++;
    if (st0 !== 8'b0100_0000) begin
      n_fail++; $display("FAIL reset_flags_comb: got %b exp %b", st0, 8'b0100_0000);
    end
    n_checks++;
    if (st1 !== 8'b0100_0000) begin
      n_fail++; $display("FAIL reset_flags_reg: got %b exp %b", st1, 8'b0100_0000);
    end
    n_checks++;
    if ({rv0, dout0, rv1, dout1} !== '0) begin
      n_fail++; $display("FAIL reset_data: got rv0=%b d0=%h rv1=%b d1=%h exp all 0", rv0, dout0, rv1, dout1);
    end
    advance();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, W'(i));
      advance();
    end
    step(0, 0, '0);
    n_checks++;
    if ({full0, empty0, cnt0} !== {1'b1, 1'b0, 3'd4}) begin
      n_fail++; $display("FAIL fill_full: got full=%b empty=%b count=%0d exp 1/0/4", full0, empty0, cnt0);
    end
    n_checks++;
    if (st1 !== exp_flags()) begin
      n_fail++; $display("FAIL fill_flags_reg: got %b exp %b", st1, exp_flags());
    end
    advance();
    for (int i = 0; i < 4; i++) begin
      step(0, 1, '0);
      n_checks++;
      if ({rv0, dout0} !== {1'b1, W'(i + 1)}) begin
        n_fail++; $display("FAIL drain_comb[%0d]: got rv=%b d=%h exp 1/%h", i, rv0, dout0, W'(i + 1));
      end
      n_checks++;
      if ({rv1, dout1} !== {m_rv1, m_d1}) begin
        n_fail++; $display("FAIL drain_reg_lag[%0d]: got rv=%b d=%h exp %b/%h", i, rv1, dout1, m_rv1, m_d1);
      end
      advance();
    end
    step(0, 0, '0);
    n_checks++;
    if ({rv1, dout1} !== {1'b1, W'(4)}) begin
      n_fail++; $display("FAIL drain_reg_last: got rv=%b d=%h exp 1/00004", rv1, dout1);
    end
    n_checks++;
    if ({empty0, cnt0, rv0, dout0} !== {1'b1, 3'd0, 1'b0, W'(0)}) begin
      n_fail++; $display("FAIL drain_empty: got empty=%b count=%0d rv=%b d=%h", empty0, cnt0, rv0, dout0);
    end
    advance();
  endtask

  task automatic test_overflow();
    logic [W-1:0] oldest;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, W'($urandom));
      advance();
    end
    oldest = q[0];
    step(1, 0, 17'h1FFFF);
    advance();
    step(0, 0, '0);
    n_checks++;
    if ({ovf0, cnt0, ovf1, cnt1} !== {1'b1, 3'd4, 1'b1, 3'd4}) begin
      n_fail++; $display("FAIL overflow_set: got ovf=%b count=%0d (reg ovf=%b count=%0d) exp 1/4", ovf0, cnt0, ovf1, cnt1);
    end
    advance();
    step(1, 1, 17'h1FFFF);
    n_checks++;
    if ({rv0, dout0} !== {1'b1, oldest}) begin
      n_fail++; $display("FAIL full_rw_out: got rv=%b d=%h exp 1/%h", rv0, dout0, oldest);
    end
    advance();
    step(0, 0, '0);
    n_checks++;
    if ({full0, cnt0, ovf0, rv1, dout1} !== {1'b1, 3'd4, 1'b1, 1'b1, oldest}) begin
      n_fail++; $display("FAIL full_rw_state: got full=%b count=%0d ovf=%b rv1=%b d1=%h exp 1/4/1/1/%h",
                         full0, cnt0, ovf0, rv1, dout1, oldest);
    end
    advance();
    for (int i = 0; i < 4; i++) begin
      step(0, 1, '0);
      n_checks++;
      if ({rv0, dout0} !== {1'b1, e_dout0} || (i == 3 && dout0 !== 17'h1FFFF)) begin
        n_fail++; $display("FAIL overflow_drain[%0d]: got rv=%b d=%h exp 1/%h", i, rv0, dout0, e_dout0);
      end
      advance();
    end
  endtask

  task automatic test_empty_rw();
    do_reset();
    step(1, 1, 17'h0ABCD);
    n_checks++;
    if ({rv0, dout0} !== '0) begin
      n_fail++; $display("FAIL empty_rw_nobypass: got rv=%b d=%h exp 0/00000", rv0, dout0);
    end
    advance();
    step(0, 1, '0);
    n_checks++;
    if ({cnt0, udf0, udf1, rv1} !== {3'd1, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL empty_rw_state: got count=%0d udf=%b udf_reg=%b rv_reg=%b exp 1/1/1/0", cnt0, udf0, udf1, rv1);
    end
    n_checks++;
    if ({rv0, dout0} !== {1'b1, 17'h0ABCD}) begin
      n_fail++; $display("FAIL empty_rw_read: got rv=%b d=%h exp 1/0abcd", rv0, dout0);
    end
    advance();
    step(0, 0, '0);
    n_checks++;
    if ({rv1, dout1} !== {1'b1, 17'h0ABCD}) begin
      n_fail++; $display("FAIL empty_rw_read_reg: got rv=%b d=%h exp 1/0abcd", rv1, dout1);
    end
    advance();
  endtask

  task automatic test_random();
    bit w, r;
    do_reset();
    for (int cyc = 0; cyc < 160; cyc++) begin
      // Alternate write-heavy and read-heavy phases to hit both full and empty.
      if ((cyc / 20) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 2) == 0);
      end else begin
        w = ($urandom_range(0, 2) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      step(w, r, W'($urandom));
      n_checks++;
      if (st0 !== exp_flags() || st1 !== exp_flags()) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got %b / %b exp %b", cyc, st0, st1, exp_flags());
      end
      n_checks++;
      if (af0 !== (q.size() >= AF)) begin
        n_fail++; $display("FAIL rand_almost_full[%0d]: got %b exp %b (occupancy %0d)", cyc, af0, q.size() >= AF, q.size());
      end
      n_checks++;
      if ({rv0, dout0} !== {e_rd_ok, e_dout0}) begin
        n_fail++; $display("FAIL rand_out_comb[%0d]: got rv=%b d=%h exp %b/%h", cyc, rv0, dout0, e_rd_ok, e_dout0);
      end
      n_checks++;
      if ({rv1, dout1} !== {m_rv1, m_d1}) begin
        n_fail++; $display("FAIL rand_out_reg[%0d]: got rv=%b d=%h exp %b/%h", cyc, rv1, dout1, m_rv1, m_d1);
      end
      advance();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(1, 0, W'($urandom)); advance();
    step(1, 0, W'($urandom)); advance();
    step(0, 1, '0); advance();
    rst = 1'b1;
    step(1, 1, W'($urandom));
    advance();
    rst = 1'b0;
    step(0, 0, '0);
    n_checks++;
    if (st0 !== 8'b0100_0000 || st1 !== 8'b0100_0000) begin
      n_fail++; $display("FAIL midreset_flags: got %b / %b exp 01000000", st0, st1);
    end
    n_checks++;
    if ({rv1, dout1} !== '0) begin
      n_fail++; $display("FAIL midreset_reg_out: got rv=%b d=%h exp 0/00000", rv1, dout1);
    end
    advance();
    step(1, 0, 17'h00111); advance();
    step(1, 0, 17'h00222); advance();
    step(0, 1, '0);
    n_checks++;
    if ({rv0, dout0} !== {1'b1, 17'h00111}) begin
      n_fail++; $display("FAIL midreset_read0: got rv=%b d=%h exp 1/00111", rv0, dout0);
    end
    advance();
    step(0, 1, '0);
    n_checks++;
    if ({rv0, dout0, rv1, dout1} !== {1'b1, 17'h00222, 1'b1, 17'h00111}) begin
      n_fail++; $display("FAIL midreset_read1: got d0=%h d1=%h exp 00222/00111", dout0, dout1);
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_empty_rw();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
